// File: rtl/psum_drain.sv
// Read-side drain engine for the PE-array partial-sum buffer: sweeps the buffer,
// applies ReLU / arithmetic shift / saturation and streams results over valid/ready.
module psum_drain #(
   parameter int unsigned PSUM_WID = 24,
   parameter int unsigned ADDR_WID = 5,
   parameter int unsigned NUM_PSUM = 27,
   parameter int unsigned OUT_WID  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                flush,
   input  logic                relu_en,
   input  logic [3:0]          shift,
   output logic [ADDR_WID-1:0] p_buff_r_addr,
   input  logic [PSUM_WID-1:0] p_buff_r_data,
   output logic [OUT_WID-1:0]  out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam logic [ADDR_WID-1:0] LAST_ADDR = ADDR_WID'(NUM_PSUM - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_WID-1:0] addr_q;
   logic [OUT_WID-1:0]  data_q;
   logic                valid_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;
   logic                relu_q;
   logic [3:0]          shift_q;

   logic signed [PSUM_WID-1:0] relu_y;
   logic signed [PSUM_WID-1:0] shift_z;
   logic [PSUM_WID-OUT_WID:0]  z_hi;
   logic [OUT_WID-1:0]         psum_proc_d;
   logic                       load;

   // z fits OUT_WID exactly when all bits from the OUT_WID sign position upward agree
   always_comb begin
      relu_y = $signed(p_buff_r_data);
      if (relu_q && p_buff_r_data[PSUM_WID-1]) begin
         relu_y = '0;
      end
      shift_z = relu_y >>> shift_q;
      z_hi    = shift_z[PSUM_WID-1:OUT_WID-1];
      if ((z_hi == '0) || (z_hi == '1)) begin
         psum_proc_d = shift_z[OUT_WID-1:0];
      end else if (shift_z[PSUM_WID-1]) begin
         psum_proc_d = {1'b1, {(OUT_WID-1){1'b0}}};
      end else begin
         psum_proc_d = {1'b0, {(OUT_WID-1){1'b1}}};
      end
   end

   assign load = !valid_q || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         relu_q  <= 1'b0;
         shift_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         addr_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // a start coinciding with the done pulse is dropped
               if (start && !done_q) begin
                  relu_q  <= relu_en;
                  shift_q <= shift;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= READ;
               end
            end
            READ: begin
               if (load) begin
                  data_q  <= psum_proc_d;
                  valid_q <= 1'b1;
                  if (addr_q == LAST_ADDR) begin
                     last_q  <= 1'b1;
                     state_q <= WAIT;
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            WAIT: begin
               if (valid_q && out_ready) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  addr_q  <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign p_buff_r_addr = addr_q;
   assign out_data      = data_q;
   assign out_valid     = valid_q;
   assign out_last      = last_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed self-checking bench for psum_drain: cycle-exact drain, post-processing,
// back-pressure, flush, start filtering and asynchronous reset.
module tb_psum_drain;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       flush;
   logic       relu_en;
   logic [3:0] shift;
   logic [4:0] p_buff_r_addr;
   logic [23:0] p_buff_r_data;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;

   logic signed [23:0] mem [0:31];
   int exp_q [0:26];
   int got_data [0:63];
   int got_last [0:63];
   int nb;
   int checks   = 0;
   int failures = 0;

   assign p_buff_r_data = mem[p_buff_r_addr];

   always #5 clk = ~clk;

   psum_drain #(
      .PSUM_WID(24),
      .ADDR_WID(5),
      .NUM_PSUM(27),
      .OUT_WID(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .flush(flush),
      .relu_en(relu_en),
      .shift(shift),
      .p_buff_r_addr(p_buff_r_addr),
      .p_buff_r_data(p_buff_r_data),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .busy(busy),
      .done(done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_basic;
      for (int i = 0; i < 32; i++) mem[i] = 24'(i - 13);
      for (int i = 0; i < 27; i++) exp_q[i] = i - 13;
   endtask

   task automatic fill_zero;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      for (int i = 0; i < 27; i++) exp_q[i] = 0;
   endtask

   // leaves the bench on the cycle where the first element should be valid
   task automatic start_drain(input logic r, input logic [3:0] s);
      relu_en = r;
      shift   = s;
      start   = 1'b1;
      step();
      start   = 1'b0;
      relu_en = 1'b0;
      shift   = 4'd0;
      chk("busy_after_start", busy, 1);
      chk("no_valid_first_cycle", out_valid, 0);
      step();
   endtask

   task automatic collect(input int bp, input int budget);
      int cyc;
      logic seen_done;
      logic stalled;
      int held;
      cyc = 0;
      nb = 0;
      seen_done = 1'b0;
      stalled = 1'b0;
      held = 0;
      while (!seen_done && cyc < budget) begin
         out_ready = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (stalled) chk("stall_data_stable", $signed(out_data), held);
         chk("addr_in_range", (p_buff_r_addr <= 5'd26), 1);
         if (out_valid && out_ready) begin
            if (nb < 64) begin
               got_data[nb] = int'($signed(out_data));
               got_last[nb] = int'(out_last);
            end
            nb++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            held = int'($signed(out_data));
         end
         step();
         cyc++;
         if (done) seen_done = 1'b1;
      end
      out_ready = 1'b1;
      chk("done_within_budget", seen_done, 1);
   endtask

   task automatic compare(input string tag);
      int lasts;
      lasts = 0;
      chk({tag, "_beat_count"}, nb, 27);
      for (int i = 0; i < 27 && i < nb; i++) begin
         chk({tag, "_data"}, got_data[i], exp_q[i]);
         lasts += got_last[i];
      end
      if (nb >= 27) chk({tag, "_last_on_26"}, got_last[26], 1);
      chk({tag, "_last_count"}, lasts, 1);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      relu_en = 1'b0;
      shift = 4'd0;
      out_ready = 1'b1;
      fill_basic();
      #2;
      chk("rst_addr", p_buff_r_addr, 0);
      chk("rst_data", $signed(out_data), 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      step();
      rst = 1'b1;
      step();

      // cycle-exact drain with an ignored start (different config) at beat 5
      start_drain(1'b0, 4'd0);
      for (int k = 0; k < 27; k++) begin
         chk("basic_valid", out_valid, 1);
         chk("basic_data", $signed(out_data), k - 13);
         chk("basic_last", out_last, (k == 26));
         if (k == 5) begin
            start = 1'b1;
            relu_en = 1'b1;
            shift = 4'd4;
         end
         step();
         start = 1'b0;
         relu_en = 1'b0;
         shift = 4'd0;
      end
      chk("basic_done", done, 1);
      chk("basic_busy_low", busy, 0);
      chk("basic_valid_low", out_valid, 0);
      chk("basic_addr_zero", p_buff_r_addr, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_on_done_ignored", busy, 0);
      chk("done_single_pulse", done, 0);
      step();

      // ReLU + shift 2
      fill_zero();
      mem[0] = -24'sd50;   exp_q[0] = 0;
      mem[1] = 24'sd300;   exp_q[1] = 75;
      mem[2] = 24'sd1000;  exp_q[2] = 127;
      mem[3] = -24'sd1000; exp_q[3] = 0;
      start_drain(1'b1, 4'd2);
      collect(0, 100);
      compare("relu_shift");
      step();

      // negative saturation and floor with shift 1
      fill_zero();
      mem[0] = -24'sd1000; exp_q[0] = -128;
      mem[1] = -24'sd3;    exp_q[1] = -2;
      mem[2] = 24'sd255;   exp_q[2] = 127;
      start_drain(1'b0, 4'd1);
      collect(0, 100);
      compare("sat_floor");
      step();

      // back-pressure with ready pattern 1,0,0
      fill_basic();
      start_drain(1'b0, 4'd0);
      collect(1, 200);
      compare("backpressure");
      step();

      // flush after 10 accepted beats
      start_drain(1'b0, 4'd0);
      for (int k = 0; k < 10; k++) begin
         chk("pre_flush_data", $signed(out_data), k - 13);
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);
      chk("flush_busy", busy, 0);
      chk("flush_addr", p_buff_r_addr, 0);
      chk("flush_last", out_last, 0);
      chk("flush_done", done, 0);
      step();
      chk("flush_no_done_later", done, 0);
      start_drain(1'b0, 4'd0);
      collect(0, 100);
      compare("redrain");
      step();

      // asynchronous reset between clock edges at beat 12
      start_drain(1'b0, 4'd0);
      for (int k = 0; k < 12; k++) step();
      chk("pre_reset_data", $signed(out_data), -1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", $signed(out_data), 0);
      chk("arst_last", out_last, 0);
      chk("arst_busy", busy, 0);
      chk("arst_addr", p_buff_r_addr, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post_reset_done", done, 0);
      chk("post_reset_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
